// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash audio sample fetcher.
package flash_reader_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ       = 2'd1,
    WAIT_VALID = 2'd2,
    STROBE     = 2'd3
  } state_t;

  localparam int          FLASH_WORD_W   = 32;
  localparam int          SAMPLE_W       = 16;
  localparam logic [3:0]  BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/flash_reader.sv
// Fetches one 32-bit flash word per sample trigger and presents alternating
// 16-bit halves (low first) on audio_out, advancing the word after the high half.
module flash_reader
  import flash_reader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    kybrd_pause,
  input  logic                    startsamplenow,
  input  logic                    flsh_waitrequest,
  output logic                    flsh_read,
  input  logic [FLASH_WORD_W-1:0] flsh_readdata,
  input  logic                    flsh_readdatavalid,
  output logic [3:0]              flsh_byteenable,
  output logic                    address_change,
  output logic                    audio_enable,
  output logic [SAMPLE_W-1:0]     audio_out
);

  state_t state;
  logic   half;

  assign flsh_byteenable = BYTEENABLE_ALL;

  // Strobes are registered alongside the state so each output mirrors the
  // state it belongs to without any combinational decode on the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      half           <= 1'b0;
      audio_out      <= '0;
      flsh_read      <= 1'b0;
      audio_enable   <= 1'b0;
      address_change <= 1'b0;
    end else begin
      audio_enable   <= 1'b0;
      address_change <= 1'b0;
      case (state)
        IDLE: begin
          if (startsamplenow && !kybrd_pause) begin
            state     <= READ;
            flsh_read <= 1'b1;
          end
        end
        READ: begin
          if (!flsh_waitrequest) begin
            state     <= WAIT_VALID;
            flsh_read <= 1'b0;
          end
        end
        WAIT_VALID: begin
          if (flsh_readdatavalid) begin
            audio_out      <= half ? flsh_readdata[FLASH_WORD_W-1:SAMPLE_W]
                                   : flsh_readdata[SAMPLE_W-1:0];
            audio_enable   <= 1'b1;
            address_change <= half;
            state          <= STROBE;
          end
        end
        STROBE: begin
          half  <= ~half;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// Randomized bench for flash_reader against a sample-level reference model.
module tb_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        kybrd_pause;
  logic        startsamplenow;
  logic        flsh_waitrequest;
  logic        flsh_read;
  logic [31:0] flsh_readdata;
  logic        flsh_readdatavalid;
  logic [3:0]  flsh_byteenable;
  logic        address_change;
  logic        audio_enable;
  logic [15:0] audio_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: which half comes next and the sample on display.
  int          model_half  = 0;
  logic [15:0] model_audio = 16'h0000;
  bit          prev_held   = 0;

  always #5 clk = ~clk;

  flash_reader dut (
    .clk                (clk),
    .reset              (reset),
    .kybrd_pause        (kybrd_pause),
    .startsamplenow     (startsamplenow),
    .flsh_waitrequest   (flsh_waitrequest),
    .flsh_read          (flsh_read),
    .flsh_readdata      (flsh_readdata),
    .flsh_readdatavalid (flsh_readdatavalid),
    .flsh_byteenable    (flsh_byteenable),
    .address_change     (address_change),
    .audio_enable       (audio_enable),
    .audio_out          (audio_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete sample: trigger, optional waitrequest stall, data after vdelay
  // cycles. keep_trig leaves the trigger high so the next sample follows at once.
  task automatic do_sample(input logic [31:0] word, input int stall, input int vdelay,
                           input bit keep_trig);
    int n;
    int reads;
    logic [15:0] exp_audio;
    bit exp_addr;
    startsamplenow = 1'b1;
    kybrd_pause    = 1'b0;
    n = 0;
    while (!flsh_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("read_start", {31'd0, flsh_read}, 32'd1);
    if (prev_held) check_eq("b2b_gap", n, 1);
    if (!keep_trig) startsamplenow = 1'b0;
    reads = 0;
    while (flsh_read && reads < 50) begin
      reads++;
      check_eq("no_en_in_read", {31'd0, audio_enable}, 32'd0);
      flsh_waitrequest = (reads <= stall);
      @(negedge clk);
    end
    check_eq("read_cycles", reads, stall + 1);
    flsh_waitrequest = 1'($urandom_range(0, 1));
    for (int i = 1; i < vdelay; i++) begin
      kybrd_pause = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("no_en_wait", {31'd0, audio_enable}, 32'd0);
      check_eq("audio_hold_wait", {16'd0, audio_out}, {16'd0, model_audio});
    end
    kybrd_pause        = 1'b0;
    flsh_readdata      = word;
    flsh_readdatavalid = 1'b1;
    @(negedge clk);
    flsh_readdatavalid = 1'b0;
    flsh_readdata      = $urandom;
    exp_audio   = (model_half == 1) ? word[31:16] : word[15:0];
    exp_addr    = (model_half == 1);
    model_audio = exp_audio;
    model_half  = 1 - model_half;
    check_eq("audio_enable", {31'd0, audio_enable}, 32'd1);
    check_eq("audio_out", {16'd0, audio_out}, {16'd0, exp_audio});
    check_eq("address_change", {31'd0, address_change}, {31'd0, exp_addr});
    check_eq("read_in_strobe", {31'd0, flsh_read}, 32'd0);
    @(negedge clk);
    check_eq("enable_pulse_end", {31'd0, audio_enable}, 32'd0);
    check_eq("addr_pulse_end", {31'd0, address_change}, 32'd0);
    check_eq("audio_held", {16'd0, audio_out}, {16'd0, model_audio});
    prev_held = keep_trig;
    $display("sample word=%h stall=%0d vdelay=%0d audio=%h addr=%0d", word, stall, vdelay,
             audio_out, exp_addr);
  endtask

  initial begin
    int seen;
    reset              = 1'b1;
    kybrd_pause        = 1'b0;
    startsamplenow     = 1'b0;
    flsh_waitrequest   = 1'b0;
    flsh_readdata      = 32'h0;
    flsh_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_read", {31'd0, flsh_read}, 32'd0);
    check_eq("rst_en", {31'd0, audio_enable}, 32'd0);
    check_eq("rst_addr", {31'd0, address_change}, 32'd0);
    check_eq("rst_audio", {16'd0, audio_out}, 32'd0);
    check_eq("byteenable", {28'd0, flsh_byteenable}, 32'hF);

    // Directed: low half, high half, then a stalled read.
    do_sample(32'hDEADBEEF, 0, 5, 1'b0);
    do_sample(32'hDEADBEEF, 0, 2, 1'b0);
    do_sample(32'h12345678, 3, 1, 1'b0);

    // Paused trigger must not start a read.
    kybrd_pause    = 1'b1;
    startsamplenow = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (flsh_read) seen++;
    end
    check_eq("pause_blocks", seen, 0);

    // Released: level trigger yields back-to-back alternating samples.
    prev_held = 0;
    for (int i = 0; i < 4; i++) do_sample(32'hDEADBEEF, 0, 1, (i != 3));
    prev_held = 0;

    // Reset while waiting for data: late valid must be ignored.
    startsamplenow = 1'b1;
    seen = 0;
    while (!flsh_read && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    startsamplenow   = 1'b0;
    flsh_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset              = 1'b0;
    flsh_readdata      = 32'hCAFEF00D;
    flsh_readdatavalid = 1'b1;
    @(negedge clk);
    flsh_readdatavalid = 1'b0;
    model_audio = 16'h0000;
    model_half  = 0;
    check_eq("rst_mid_en", {31'd0, audio_enable}, 32'd0);
    check_eq("rst_mid_audio", {16'd0, audio_out}, 32'd0);
    check_eq("rst_mid_read", {31'd0, flsh_read}, 32'd0);
    do_sample(32'hA5A55A5A, 0, 1, 1'b0);

    // Randomized samples.
    for (int i = 0; i < 24; i++)
      do_sample($urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
